knap_search: RTL
================

# knap_search

Sequential brute-force search engine for the knapsack oracle. It enumerates every item-selection mask and evaluates each one against the shared value, weight and volume tables. Each satisfying mask is streamed out over a valid/ready port, and the engine also tracks the best (highest-value) solution. It is the driving end of the oracle check: the engine generates candidates and consumes `valid`.

## Interface
- `N_ITEMS`, default 6: number of items, which is also the candidate mask width.
- `VW`, default 9: width of the totals accumulators. Must satisfy `VW >= 6 + clog2(N_ITEMS)`.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, **asynchronous, active-high**.
- `start`, input, 1: begin a search. Sampled only in IDLE or DONE.
- `abort`, input, 1: return to IDLE and drop any buffered solution.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `sol_valid`, output, 1: output buffer holds a solution.
- `sol_ready`, input, 1: consumer accepts the solution.
- `sol_mask`, output, N_ITEMS: the solution mask. Bit 0 is item A.
- `sol_value`, output, VW: total value of `sol_mask`.
- `best_found`, output, 1: at least one solution has been found this search.
- `best_mask`, output, N_ITEMS: mask of the best solution so far.
- `best_value`, output, VW: value of the best solution so far.
- `sol_count`, output, N_ITEMS+1: number of solutions found this search.

## Operation
- **Reset values:** every output is 0, the state is IDLE and the candidate counter `cand` is 0.
- **State machine:** the states are IDLE, RUN and DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after the last candidate (all ones) has been evaluated and the output buffer is empty.
  - DONE → RUN on `start`.
  - Any state → IDLE on `abort`. `abort` wins over `start`.
- **Entering RUN:**
  - `cand`, `sol_count`, `best_*` and the output buffer are all cleared.
  - `start` is ignored while in RUN.
- **Evaluation:**
  - Evaluation is combinational on `cand`.
  - Totals are sums of the table entries for the set bits, computed at VW bits, so they never wrap.
  - A candidate passes when all three hold: value ≥ MIN_VALUE, weight ≤ MAX_WEIGHT, volume ≤ MAX_VOLUME.
- **Each RUN cycle:**
  - A failing candidate advances `cand`.
  - A passing candidate is written to the one-entry output buffer, `sol_count` increments, and `cand` advances.
  - If the candidate passes but the buffer is full and not draining this cycle (`sol_valid && !sol_ready`), `cand` holds (stall). Nothing is lost.
- **Output handshake:**
  - A transfer occurs on `sol_valid && sol_ready`.
  - While a solution is pending, `sol_mask` and `sol_value` stay stable.
  - A drain and a load in the same cycle is legal and gives back-to-back solutions.
- **Best tracking:**
  - The best solution is updated at buffer load when value > `best_value`, or when it is the first solution.
  - On a tie, the earlier (lower) mask is kept.
- **Counter at the last candidate:** `cand` does not wrap. At the all-ones mask the counter saturates, and exit is controlled by the state machine.
- **In DONE:** `best_*` and `sol_count` hold until the next `start`.
- **Reset mid-search:** the engine returns immediately to the reset values, and any pending solution is discarded.

## Timing
- `start` is sampled at edge t. Candidate k is evaluated in cycle t+1+k when there are no stalls.
- Solution latency: a passing candidate k gives `sol_valid` high from cycle t+2+k.
- `busy` is high from t+1.
- Full search with `sol_ready` tied high:
  - DONE is entered at t+1+2^N_ITEMS.
  - For N_ITEMS=6, `done` is high from t+65.
- Each cycle of held `sol_ready=0` while a pass is pending adds one stall cycle.
- `sol_count`, `best_*` and `sol_valid` all update on the same edge as the buffer load.

## Structure
- Package `knap_pkg` holds:
  - `N_ITEMS`.
  - Tables VALUE = {4,2,2,1,10,20}, WEIGHT = {12,1,2,1,4,1} and VOLUME = {10,2,1,4,3,12}, indexed A..F.
  - MIN_VALUE=15, MAX_WEIGHT=16, MAX_VOLUME=10.
  - The state enum.
- Sub-module `knap_eval`: a combinational oracle (mask → pass, value) driven by the package tables. It is instantiated once in `knap_search`.

## Test plan
- **Full search, `sol_ready`=1:** `start` at t → exactly one solution, `sol_mask`=0x1E (B,C,D,E), `sol_value`=15, `sol_valid` for one cycle at t+32. Then `done` at t+65 with `sol_count`=1, `best_mask`=0x1E, `best_value`=15.
- **Backpressure:** hold `sol_ready`=0 from t to t+40 → `sol_valid` is high with 0x1E stable from t+32 until the accept. Search continues (no further passes) and `done` rises at t+65 only after the drain.
- **Abort mid-search:** assert `abort` at t+20 → IDLE next cycle, `busy`=0 and no solution emitted. A subsequent `start` reproduces the first scenario exactly.
- **Asynchronous reset at t+33 while `sol_valid`=1:** all outputs go to 0 immediately without waiting for `clk`, and the pending solution is discarded.
- **Re-start:**
  - `start` while in RUN is ignored; the timing of the first scenario is unchanged.
  - `start` in DONE clears `sol_count` and `best_found` on the next cycle and repeats the search.
- **Oracle exhaustive check:** compare `knap_eval` against a model for all 64 masks → only 0x1E passes. Also check mask 0x3F gives value 39 with no truncation at VW=9.

Source files
------------

// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack search engine.
// Holds the item tables (indexed A..F, A at index 0), the pass thresholds
// and the search state encoding.
package knap_pkg;

  localparam int unsigned N_ITEMS = 6;

  localparam int unsigned VALUE  [N_ITEMS] = '{4, 2, 2, 1, 10, 20};
  localparam int unsigned WEIGHT [N_ITEMS] = '{12, 1, 2, 1, 4, 1};
  localparam int unsigned VOLUME [N_ITEMS] = '{10, 2, 1, 4, 3, 12};

  localparam int unsigned MIN_VALUE  = 15;
  localparam int unsigned MAX_WEIGHT = 16;
  localparam int unsigned MAX_VOLUME = 10;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/knap_eval.sv
// Combinational knapsack oracle.
// Ports:
//   mask  - candidate selection, bit 0 is item A
//   pass  - value >= MIN_VALUE, weight <= MAX_WEIGHT, volume <= MAX_VOLUME
//   value - total value of the selected items
// Totals are accumulated at VW bits, wide enough that they never wrap.
module knap_eval #(
  parameter int unsigned N_ITEMS = 6,
  parameter int unsigned VW      = 9
) (
  input  logic [N_ITEMS-1:0] mask,
  output logic               pass,
  output logic [VW-1:0]      value
);
  import knap_pkg::*;

  logic [VW-1:0] weight;
  logic [VW-1:0] volume;

  always_comb begin
    value  = '0;
    weight = '0;
    volume = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        value  = value  + VW'(VALUE[i]);
        weight = weight + VW'(WEIGHT[i]);
        volume = volume + VW'(VOLUME[i]);
      end
    end
    pass = (value >= VW'(MIN_VALUE)) &&
           (weight <= VW'(MAX_WEIGHT)) &&
           (volume <= VW'(MAX_VOLUME));
  end

endmodule

// File: rtl/knap_search.sv
// Brute-force knapsack search engine.
// Enumerates every selection mask, streams each passing mask through a
// one-entry valid/ready buffer and tracks the highest-value solution.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, abort        - begin a search (IDLE/DONE only) / return to IDLE
//   busy, done          - state is RUN / state is DONE
//   sol_valid/ready     - solution handshake; sol_mask, sol_value payload
//   best_found/mask/value - best solution so far this search
//   sol_count           - number of solutions found this search
module knap_search #(
  parameter int unsigned N_ITEMS = 6,
  parameter int unsigned VW      = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [N_ITEMS-1:0] sol_mask,
  output logic [VW-1:0]      sol_value,
  output logic               best_found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [VW-1:0]      best_value,
  output logic [N_ITEMS:0]   sol_count
);
  import knap_pkg::*;

  state_t             state;
  logic [N_ITEMS-1:0] cand;
  // Set once the all-ones candidate has been evaluated; the counter itself
  // saturates there, so this keeps the last mask from being counted twice.
  logic               last_seen;

  logic               pass;
  logic [VW-1:0]      value;

  logic in_run, can_load, eval_pass, load, stall, at_last, finishing, empty_next;

  knap_eval #(.N_ITEMS(N_ITEMS), .VW(VW)) u_eval (
    .mask  (cand),
    .pass  (pass),
    .value (value)
  );

  always_comb begin
    in_run     = (state == S_RUN);
    can_load   = !sol_valid || sol_ready;
    eval_pass  = in_run && !last_seen && pass;
    load       = eval_pass && can_load;
    stall      = eval_pass && !can_load;
    at_last    = (cand == '1);
    finishing  = last_seen || (at_last && !stall);
    empty_next = !load && can_load;
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cand       <= '0;
      last_seen  <= 1'b0;
      sol_valid  <= 1'b0;
      sol_mask   <= '0;
      sol_value  <= '0;
      best_found <= 1'b0;
      best_mask  <= '0;
      best_value <= '0;
      sol_count  <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      sol_valid <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            cand       <= '0;
            last_seen  <= 1'b0;
            sol_valid  <= 1'b0;
            sol_mask   <= '0;
            sol_value  <= '0;
            best_found <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
            sol_count  <= '0;
          end
        end
        S_RUN: begin
          if (sol_valid && sol_ready) sol_valid <= 1'b0;
          if (load) begin
            sol_valid <= 1'b1;
            sol_mask  <= cand;
            sol_value <= value;
            sol_count <= sol_count + (N_ITEMS+1)'(1);
            // Strict compare keeps the earlier (lower) mask on a tie.
            if (!best_found || (value > best_value)) begin
              best_mask  <= cand;
              best_value <= value;
            end
            best_found <= 1'b1;
          end
          if (!last_seen && !stall) begin
            if (at_last) last_seen <= 1'b1;
            else         cand      <= cand + N_ITEMS'(1);
          end
          if (finishing && empty_next) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
